// File: rtl/step_dda.sv
// Move-command step/direction generator: 32-bit DDA phase accumulator with a
// linearly ramped rate, fixed-width step pulses and direction setup enforcement.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for a move command, cmd_ready high
// S_DIR_SETUP | dir just changed; counting step-low cycles before stepping
// S_RUN       | ticking the DDA every tick_div cycles until remaining is 0
module step_dda #(
    parameter int unsigned tick_div          = 16,
    parameter int unsigned step_pulse_cycles = 8,
    parameter int unsigned dir_setup_cycles  = 4,
    parameter int unsigned duration_bits     = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_dir,
    input  logic [duration_bits-1:0] cmd_duration,
    input  logic [31:0]              cmd_rate,
    input  logic [31:0]              cmd_accel,
    input  logic                     abort,
    output logic                     step,
    output logic                     dir,
    output logic                     busy,
    output logic                     done
);

    localparam int PW  = (tick_div > 1) ? $clog2(tick_div) : 1;
    localparam int PCW = $clog2(step_pulse_cycles + 1);
    localparam int SCW = $clog2(dir_setup_cycles + 1);

    localparam logic [PW-1:0]            TICK_LAST   = PW'(tick_div - 1);
    localparam logic [PW-1:0]            PRE_ONE     = PW'(1);
    localparam logic [PCW-1:0]           PULSE_LOAD  = PCW'(step_pulse_cycles - 1);
    localparam logic [PCW-1:0]           PULSE_ONE   = PCW'(1);
    localparam logic [SCW-1:0]           SETUP_LOAD  = SCW'(dir_setup_cycles - 1);
    localparam logic [SCW-1:0]           SETUP_ONE   = SCW'(1);
    localparam logic [duration_bits-1:0] DUR_ONE     = duration_bits'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIR_SETUP,
        S_RUN
    } state_t;

    state_t                   state;
    logic [31:0]              acc;
    logic [31:0]              rate;
    logic [31:0]              accel;
    logic [duration_bits-1:0] remaining;
    logic [PW-1:0]            prescale;
    logic [PCW-1:0]           pulse_cnt;
    logic [SCW-1:0]           setup_cnt;

    logic [32:0]              acc_sum;
    logic signed [33:0]       rate_sum;
    logic [31:0]              rate_next;

    assign acc_sum = {1'b0, acc} + {1'b0, rate};

    // Rate ramps by a signed step but is pinned to the unsigned 32-bit range.
    always_comb begin
        rate_sum  = $signed({2'b00, rate}) + $signed({{2{accel[31]}}, accel});
        rate_next = rate_sum[31:0];
        if (rate_sum[33]) begin
            rate_next = '0;
        end else if (rate_sum[32]) begin
            rate_next = '1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            acc       <= '0;
            rate      <= '0;
            accel     <= '0;
            remaining <= '0;
            prescale  <= '0;
            pulse_cnt <= '0;
            setup_cnt <= '0;
            step      <= 1'b0;
            dir       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;

            // Pulse timing runs regardless of state so aborted moves still finish their pulse.
            if (step) begin
                if (pulse_cnt == '0) begin
                    step <= 1'b0;
                end else begin
                    pulse_cnt <= pulse_cnt - PULSE_ONE;
                end
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_duration == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= cmd_duration;
                            rate      <= cmd_rate;
                            accel     <= cmd_accel;
                            prescale  <= '0;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            if (cmd_dir != dir) begin
                                dir       <= cmd_dir;
                                setup_cnt <= SETUP_LOAD;
                                state     <= S_DIR_SETUP;
                            end else begin
                                state <= S_RUN;
                            end
                        end
                    end
                end

                S_DIR_SETUP: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (!step) begin
                        if (setup_cnt == '0) begin
                            prescale <= '0;
                            state    <= S_RUN;
                        end else begin
                            setup_cnt <= setup_cnt - SETUP_ONE;
                        end
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (prescale == TICK_LAST) begin
                        prescale  <= '0;
                        acc       <= acc_sum[31:0];
                        rate      <= rate_next;
                        remaining <= remaining - DUR_ONE;
                        if (acc_sum[32]) begin
                            step      <= 1'b1;
                            pulse_cnt <= PULSE_LOAD;
                        end
                        if (remaining == DUR_ONE) begin
                            state     <= S_IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end else begin
                        prescale <= prescale + PRE_ONE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_dda.sv
// Bench for step_dda: cycle-indexed arithmetic model checked every cycle,
// plus hand-computed expectations for each directed move.
module tb_step_dda;

    localparam int TD = 4;
    localparam int PC = 2;
    localparam int DS = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [31:0] cmd_duration = '0;
    logic [31:0] cmd_rate = '0;
    logic [31:0] cmd_accel = '0;
    logic        abort = 1'b0;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;

    step_dda #(
        .tick_div(TD),
        .step_pulse_cycles(PC),
        .dir_setup_cycles(DS),
        .duration_bits(32)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_duration(cmd_duration),
        .cmd_rate(cmd_rate),
        .cmd_accel(cmd_accel),
        .abort(abort),
        .step(step),
        .dir(dir),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input longint act, input longint min);
        compared++;
        if (act < min) begin
            mismatched++;
            $display("FAIL %s: got %0d, required at least %0d", name, act, min);
        end
    endtask

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: mode 0 idle, 1 waiting for direction setup, 2 running.
    int     m_mode = 0;
    bit     m_dir = 1'b0;
    bit     m_done = 1'b0;
    longint m_step_until = 0;
    longint m_acc = 0;
    longint m_rate = 0;
    longint m_accel = 0;
    longint m_rem = 0;
    longint m_run_start = 0;
    int     m_low = 0;

    always @(posedge clk or negedge resetn) begin
        longint old;
        longint sum;
        longint r;
        bit     step_old;
        if (!resetn) begin
            m_mode = 0; m_dir = 1'b0; m_done = 1'b0; m_step_until = 0;
            m_acc = 0; m_rate = 0; m_accel = 0; m_rem = 0; m_low = 0;
        end else begin
            old      = cyc;
            step_old = (old < m_step_until);
            m_done   = 1'b0;
            case (m_mode)
                0: if (cmd_valid) begin
                    if (cmd_duration == 0) begin
                        m_done = 1'b1;
                    end else begin
                        m_rem   = longint'(cmd_duration);
                        m_rate  = longint'(cmd_rate);
                        m_accel = longint'($signed(cmd_accel));
                        if (cmd_dir != m_dir) begin
                            m_dir = cmd_dir; m_mode = 1; m_low = 0;
                        end else begin
                            m_mode = 2; m_run_start = old + 1;
                        end
                    end
                end
                1: if (abort) m_mode = 0;
                   else begin
                       if (!step_old) m_low++;
                       if (m_low == DS) begin m_mode = 2; m_run_start = old + 1; end
                   end
                2: if (abort) m_mode = 0;
                   else if ((old - m_run_start) % TD == TD - 1) begin
                       sum = m_acc + m_rate;
                       if (sum >= 64'h1_0000_0000) m_step_until = old + 1 + PC;
                       m_acc = sum % 64'h1_0000_0000;
                       r = m_rate + m_accel;
                       if (r < 0) r = 0;
                       if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF;
                       m_rate = r;
                       m_rem--;
                       if (m_rem == 0) begin m_mode = 0; m_done = 1'b1; end
                   end
                default: m_mode = 0;
            endcase
        end
    end

    int     dut_rises = 0, mod_rises = 0, dut_done_cnt = 0;
    bit     dut_prev_step = 1'b0, mod_prev_step = 1'b0, dut_prev_dir = 1'b0, gap_pending = 1'b0;
    longint dir_chg_cyc = 0, first_gap = 0;

    always @(negedge clk) begin
        bit exp_step;
        exp_step = (cyc < m_step_until);
        check_eq("step", step, exp_step);
        check_eq("dir", dir, m_dir);
        check_eq("busy", busy, m_mode != 0);
        check_eq("cmd_ready", cmd_ready, m_mode == 0);
        check_eq("done", done, m_done);
        if (step && !dut_prev_step) begin
            dut_rises++;
            if (gap_pending) begin first_gap = cyc - dir_chg_cyc; gap_pending = 1'b0; end
        end
        if (exp_step && !mod_prev_step) mod_rises++;
        if (dir !== dut_prev_dir) begin dir_chg_cyc = cyc; gap_pending = 1'b1; end
        if (done) dut_done_cnt++;
        dut_prev_step = step;
        mod_prev_step = exp_step;
        dut_prev_dir  = dir;
    end

    task automatic send(input logic d, input logic [31:0] dur, input logic [31:0] rt,
                        input logic [31:0] ac, output longint at);
        check_eq("ready_at_send", cmd_ready, 1'b1);
        cmd_dir = d; cmd_duration = dur; cmd_rate = rt; cmd_accel = ac;
        cmd_valid = 1'b1;
        at = cyc;
    endtask

    task automatic wait_done(input int budget, input string name, output longint when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin when = cyc; return; end
        end
        compared++; mismatched++;
        $display("FAIL %s: no done pulse within %0d cycles, required one", name, budget);
    endtask

    task automatic wait_step(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (step === 1'b1) return;
        end
        compared++; mismatched++;
        $display("FAIL %s: no step within %0d cycles, required one", name, budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint a, dc;
        int r0, m0, d0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_step", step, 1'b0);
        check_eq("rst_dir", dir, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_ready", cmd_ready, 1'b1);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Half-rate move, forward dir unchanged: carries on every 2nd tick.
        r0 = dut_rises; m0 = mod_rises;
        send(1'b0, 8, 32'h8000_0000, 32'h0, a);
        @(negedge clk) cmd_valid = 1'b0;
        wait_done(200, "t1_done", dc);
        check_eq("t1_done_lat", dc - a, 33);

        // Reversal issued while the last T1 pulse is still high.
        send(1'b1, 8, 32'h8000_0000, 32'h0, a);
        @(negedge clk) cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_steps", dut_rises - r0, 4);
        check_eq("t1_model_steps", mod_rises - m0, 4);
        check_eq("t1_model_acc", m_acc, 0);
        r0 = dut_rises; m0 = mod_rises;
        wait_done(300, "t2_done", dc);
        check_eq("t2_done_lat", dc - a, 38);
        check_eq("t2_dir_lat", dir_chg_cyc - a, 1);
        check_ge("t2_dir_setup", first_gap, DS);

        // Rate saturation.
        send(1'b1, 20, 32'hFFFF_FFF0, 32'h0000_0100, a);
        @(negedge clk) cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("t2_steps", dut_rises - r0, 4);
        check_eq("t2_model_steps", mod_rises - m0, 4);
        r0 = dut_rises; m0 = mod_rises;
        wait_done(400, "t3_done", dc);
        check_eq("t3_done_lat", dc - a, 81);
        check_eq("t3_model_rate", m_rate, 64'hFFFF_FFFF);
        check_eq("t3_model_acc", m_acc, 64'hFFFF_FFDD);
        repeat (3) @(negedge clk);
        check_eq("t3_steps", dut_rises - r0, 19);
        check_eq("t3_model_steps", mod_rises - m0, 19);

        // Zero duration with opposite dir: done only, dir kept.
        send(1'b0, 0, 32'h8000_0000, 32'h0, a);
        @(negedge clk) cmd_valid = 1'b0;
        check_eq("z_done", done, 1'b1);
        check_eq("z_ready", cmd_ready, 1'b1);
        check_eq("z_dir", dir, 1'b1);
        check_eq("z_busy", busy, 1'b0);
        @(negedge clk);
        check_eq("z_done_end", done, 1'b0);

        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        check_eq("idle_abort_ready", cmd_ready, 1'b1);

        // Abort while a pulse is high.
        send(1'b1, 1000, 32'h8000_0000, 32'h0, a);
        @(negedge clk) cmd_valid = 1'b0;
        wait_step(100, "ab_step");
        abort = 1'b1;
        d0 = dut_done_cnt;
        @(negedge clk) abort = 1'b0;
        check_eq("ab_busy", busy, 1'b0);
        check_eq("ab_ready", cmd_ready, 1'b1);
        check_eq("ab_inflight", step, 1'b1);
        @(negedge clk);
        check_eq("ab_step_end", step, 1'b0);
        repeat (30) @(negedge clk);
        check_eq("ab_no_done", dut_done_cnt - d0, 0);

        // Abort together with a command in idle: command wins.
        abort = 1'b1;
        send(1'b1, 100, 32'h8000_0000, 32'h0, a);
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
        check_eq("av_busy", busy, 1'b1);
        wait_step(100, "rs_step");
        #1 resetn = 1'b0;
        #1;
        check_eq("rs_step", step, 1'b0);
        check_eq("rs_busy", busy, 1'b0);
        check_eq("rs_ready", cmd_ready, 1'b1);
        check_eq("rs_dir", dir, 1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Deceleration from acc=0: rate clamps at zero before any carry.
        r0 = dut_rises; m0 = mod_rises;
        send(1'b0, 40, 32'h1000_0000, 32'hFF00_0000, a);
        @(negedge clk) cmd_valid = 1'b0;
        wait_done(400, "t4_done", dc);
        check_eq("t4_done_lat", dc - a, 161);
        check_eq("t4_model_acc", m_acc, 64'h8800_0000);
        check_eq("t4_model_rate", m_rate, 0);
        repeat (4) @(negedge clk);
        check_eq("t4_steps", dut_rises - r0, 0);
        check_eq("t4_model_steps", mod_rises - m0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
